// File: rtl/ds_operand_unit_pkg.sv
// rtl/ds_operand_unit_pkg.sv - shared widths, zero-register constant and operand source encoding
package ds_operand_unit_pkg;

  localparam int DS_NUM_FWD   = 3;
  localparam int DS_DATA_W    = 32;
  localparam int DS_ADDR_W    = 5;
  localparam int DS_PAYLOAD_W = 64;
  localparam int DS_CNT_W     = 16;

  // Flattened bypass bus widths: channel i lives at [i*W +: W].
  localparam int DS_FWD_DEST_W = DS_NUM_FWD * DS_ADDR_W;
  localparam int DS_FWD_DATA_W = DS_NUM_FWD * DS_DATA_W;

  // r0 reads as zero and is never a forwarding target.
  localparam int DS_ZERO_REG = 0;

  typedef enum logic [1:0] {
    SRC_RF   = 2'd0,
    SRC_FWD  = 2'd1,
    SRC_ZERO = 2'd2
  } src_sel_e;

endpackage

// File: rtl/ds_fwd_select.sv
// rtl/ds_fwd_select.sv - priority bypass match and mux for one source operand
module ds_fwd_select
  import ds_operand_unit_pkg::*;
#(
  parameter int NUM_FWD = DS_NUM_FWD,
  parameter int DATA_W  = DS_DATA_W,
  parameter int ADDR_W  = DS_ADDR_W
) (
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic                      i_used,
  input  logic [DATA_W-1:0]         i_rf_rdata,
  input  logic [NUM_FWD-1:0]        i_fwd_valid,
  input  logic [NUM_FWD-1:0]        i_fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] i_fwd_dest,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
  input  logic [NUM_FWD-1:0]        i_fwd_data_ok,
  output logic [DATA_W-1:0]         o_value,
  output logic                      o_not_ready
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(DS_ZERO_REG);

  logic [NUM_FWD-1:0] w_hit;
  src_sel_e           w_sel;
  logic [DATA_W-1:0]  w_fwd_data;
  logic               w_fwd_ok;

  genvar g;
  generate
    for (g = 0; g < NUM_FWD; g++) begin : g_match
      assign w_hit[g] = i_fwd_valid[g] & i_fwd_we[g] & i_used &
                        (i_fwd_dest[g*ADDR_W +: ADDR_W] == i_addr) &
                        (i_addr != ZERO_ADDR);
    end
  endgenerate

  // Walk oldest to youngest so the youngest hit overwrites; its ok bit decides the stall.
  always_comb begin
    w_sel      = SRC_RF;
    w_fwd_data = '0;
    w_fwd_ok   = 1'b1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel      = SRC_FWD;
        w_fwd_data = i_fwd_data[i*DATA_W +: DATA_W];
        w_fwd_ok   = i_fwd_data_ok[i];
      end
    end
    if (i_addr == ZERO_ADDR) begin
      w_sel = SRC_ZERO;
    end
  end

  always_comb begin
    o_value     = i_rf_rdata;
    o_not_ready = 1'b0;
    case (w_sel)
      SRC_FWD: begin
        o_value     = w_fwd_data;
        o_not_ready = ~w_fwd_ok;
      end
      SRC_ZERO: o_value = '0;
      default:  o_value = i_rf_rdata;
    endcase
  end

endmodule

// File: rtl/ds_operand_unit.sv
// rtl/ds_operand_unit.sv - decode-stage pipeline register, operand forwarding and stall tracking
module ds_operand_unit
  import ds_operand_unit_pkg::*;
#(
  parameter int NUM_FWD   = DS_NUM_FWD,
  parameter int DATA_W    = DS_DATA_W,
  parameter int ADDR_W    = DS_ADDR_W,
  parameter int PAYLOAD_W = DS_PAYLOAD_W,
  parameter int CNT_W     = DS_CNT_W
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_fs_to_ds_valid,
  input  logic [PAYLOAD_W-1:0]      i_fs_payload,
  input  logic [ADDR_W-1:0]         i_fs_src1_addr,
  input  logic [ADDR_W-1:0]         i_fs_src2_addr,
  input  logic                      i_fs_src1_used,
  input  logic                      i_fs_src2_used,
  output logic                      o_ds_allowin,
  input  logic                      i_es_allowin,
  input  logic                      i_flush,
  output logic                      o_ds_to_es_valid,
  output logic [PAYLOAD_W-1:0]      o_ds_payload,
  output logic [ADDR_W-1:0]         o_rf_raddr1,
  output logic [ADDR_W-1:0]         o_rf_raddr2,
  input  logic [DATA_W-1:0]         i_rf_rdata1,
  input  logic [DATA_W-1:0]         i_rf_rdata2,
  input  logic [NUM_FWD-1:0]        i_fwd_valid,
  input  logic [NUM_FWD-1:0]        i_fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] i_fwd_dest,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
  input  logic [NUM_FWD-1:0]        i_fwd_data_ok,
  output logic [DATA_W-1:0]         o_src1_value,
  output logic [DATA_W-1:0]         o_src2_value,
  output logic                      o_ds_stall,
  output logic [CNT_W-1:0]          o_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 r_ds_valid;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [ADDR_W-1:0]    r_src1_addr;
  logic [ADDR_W-1:0]    r_src2_addr;
  logic                 r_src1_used;
  logic                 r_src2_used;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic w_not_ready1;
  logic w_not_ready2;
  logic w_stall;
  logic w_ready_go;
  logic w_allowin;
  logic w_accept;

  ds_fwd_select #(
    .NUM_FWD(NUM_FWD),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sel1 (
    .i_addr       (r_src1_addr),
    .i_used       (r_src1_used),
    .i_rf_rdata   (i_rf_rdata1),
    .i_fwd_valid  (i_fwd_valid),
    .i_fwd_we     (i_fwd_we),
    .i_fwd_dest   (i_fwd_dest),
    .i_fwd_data   (i_fwd_data),
    .i_fwd_data_ok(i_fwd_data_ok),
    .o_value      (o_src1_value),
    .o_not_ready  (w_not_ready1)
  );

  ds_fwd_select #(
    .NUM_FWD(NUM_FWD),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sel2 (
    .i_addr       (r_src2_addr),
    .i_used       (r_src2_used),
    .i_rf_rdata   (i_rf_rdata2),
    .i_fwd_valid  (i_fwd_valid),
    .i_fwd_we     (i_fwd_we),
    .i_fwd_dest   (i_fwd_dest),
    .i_fwd_data   (i_fwd_data),
    .i_fwd_data_ok(i_fwd_data_ok),
    .o_value      (o_src2_value),
    .o_not_ready  (w_not_ready2)
  );

  assign w_stall    = r_ds_valid & (w_not_ready1 | w_not_ready2);
  assign w_ready_go = ~w_stall;
  assign w_allowin  = ~r_ds_valid | (w_ready_go & i_es_allowin);
  assign w_accept   = i_fs_to_ds_valid & w_allowin & ~i_flush;

  assign o_ds_allowin     = w_allowin;
  assign o_ds_to_es_valid = r_ds_valid & w_ready_go & ~i_flush;
  assign o_ds_stall       = w_stall;
  assign o_ds_payload     = r_payload;
  assign o_rf_raddr1      = r_src1_addr;
  assign o_rf_raddr2      = r_src2_addr;
  assign o_stall_cnt      = r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ds_valid <= 1'b0;
    end else if (i_flush) begin
      r_ds_valid <= 1'b0;
    end else if (w_allowin) begin
      r_ds_valid <= i_fs_to_ds_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_payload   <= '0;
      r_src1_addr <= '0;
      r_src2_addr <= '0;
      r_src1_used <= 1'b0;
      r_src2_used <= 1'b0;
    end else if (w_accept) begin
      r_payload   <= i_fs_payload;
      r_src1_addr <= i_fs_src1_addr;
      r_src2_addr <= i_fs_src2_addr;
      r_src1_used <= i_fs_src1_used;
      r_src2_used <= i_fs_src2_used;
    end
  end

  // Survives flush so the count reflects total hazard cycles seen.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/ds_operand_unit.md
Name: ds_operand_unit

Overview:
Decode-stage operand collection unit with parametrised forwarding.
- Holds the fs→ds pipeline register and the valid/allowin handshake.
- Resolves two source operands against NUM_FWD prioritised bypass channels and the register file.
- Generalises load-use stalling to any producer whose result is not yet ready; adds flush and a saturating stall counter.
- Sits between the fetch stage and the decode/execute logic. The decoder consumes its payload and operand outputs.

Parameters:
NUM_FWD, 3, number of bypass channels; index 0 is the youngest (EX), higher indices are older.
DATA_W, 32, operand width.
ADDR_W, 5, register address width; address 0 is hard-wired zero.
PAYLOAD_W, 64, opaque instruction bundle ({inst, pc}) carried through.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fs_to_ds_valid  in  1  upstream valid
fs_payload  in  PAYLOAD_W  instruction bundle
fs_src1_addr / fs_src2_addr  in  ADDR_W each  source register addresses
fs_src1_used / fs_src2_used  in  1 each  source is actually read
ds_allowin  out  1  ready to accept from fetch
es_allowin  in  1  execute stage ready
flush  in  1  kill the held instruction (branch redirect / exception)
ds_to_es_valid  out  1  operands resolved, instruction handed to execute
ds_payload  out  PAYLOAD_W  registered bundle
rf_raddr1 / rf_raddr2  out  ADDR_W each  registered source addresses to the external regfile
rf_rdata1 / rf_rdata2  in  DATA_W each  regfile read data (combinational read)
fwd_valid  in  NUM_FWD  channel holds a valid instruction
fwd_we  in  NUM_FWD  channel instruction writes a GPR
fwd_dest  in  NUM_FWD*ADDR_W  destination address; channel i occupies bits [i*ADDR_W +: ADDR_W]
fwd_data  in  NUM_FWD*DATA_W  result data
fwd_data_ok  in  NUM_FWD  result is available this cycle; 0 means load or multi-cycle op in flight
src1_value / src2_value  out  DATA_W each  resolved operands
ds_stall  out  1  ds_valid & operand not ready
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
Reset:
- ds_valid=0, payload and address registers = 0, stall_cnt=0.
- Consequently ds_to_es_valid=0, ds_stall=0, ds_allowin=1.

Handshake:
- ds_ready_go = ~stall.
- ds_allowin = ~ds_valid | (ds_ready_go & es_allowin).
- ds_to_es_valid = ds_valid & ds_ready_go & ~flush.

Register update:
- flush: ds_valid ← 0 and fs_to_ds_valid is ignored that cycle; flush has priority over everything else.
- Otherwise, when ds_allowin=1: ds_valid ← fs_to_ds_valid.
- When fs_to_ds_valid & ds_allowin & ~flush: latch payload, addresses and used bits.
- The register holds its value while stalled.

Operand resolution (combinational, per source s):
- hit_i = fwd_valid[i] & fwd_we[i] & (fwd_dest_i == addr_s) & used_s & (addr_s != 0).
- Winner is the lowest i with hit_i.
- If there is a winner: value = fwd_data_i; not_ready_s = ~fwd_data_ok[i].
- If there is no hit: value = rf_rdata_s.
- addr_s == 0 → value = 0, never stalls.
- Unused source → value = rf_rdata_s, never stalls.
- An older ready channel must not mask a younger not-ready hit; the youngest hit always decides.

Stall and counter:
- stall = ds_valid & (not_ready_1 | not_ready_2); ds_stall = stall.
- stall_cnt increments each cycle stall=1 and saturates at all-ones; it is not cleared by flush.
- Latency: with no hazard, one cycle from acceptance to ds_to_es_valid. Each cycle the youngest hit has fwd_data_ok=0 adds one cycle.

Boundary conditions:
- Both sources hitting different channels: each resolves independently; a stall from either holds both.
- flush during a stall: instruction dropped next cycle; ds_to_es_valid is 0 in the flush cycle.
- es_allowin=0 with operands ready: the instruction holds; values are re-resolved every cycle, since forwarding sources move.

Decomposition:
- Shared package: bus-width macros (DS_PAYLOAD_W, FWD bus widths) and the zero-register constant.
- One sub-module, ds_fwd_select: a priority match/mux for a single source, instantiated twice, loop-generated over NUM_FWD.

Test Plan:
1. No hazard: src1=r3 (rf=0x11), src2=r4 (rf=0x22), es_allowin=1 → ds_to_es_valid 1 cycle after accept; values 0x11 / 0x22.
2. Priority: ch0 dest=r3 data=0xAAAA ok=1, ch2 dest=r3 data=0xBBBB → src1_value=0xAAAA; drop ch0 → 0xBBBB.
3. Load-use: ch0 dest=r5 ok=0 for 2 cycles then ok=1 data=0x1234 → ds_stall for 2 cycles, ds_allowin=0, stall_cnt=2, then valid with 0x1234.
4. Zero/unused: src1=r0 with ch0 dest=r0 ok=0, src2 unused matching ch0 → no stall; src1_value=0.
5. Flush mid-stall: stalled on ch1 ok=0, assert flush → ds_to_es_valid never rises; ds_valid=0 next cycle; a new instruction is accepted the cycle after.
6. Back-pressure and saturation with CNT_W=4: es_allowin=0 for 3 cycles → payload stable; 20 stall cycles → stall_cnt=15.
